// File: rtl/truth_table_checker.sv
// Sweeps every input vector of a small combinational block, samples its output after a
// programmable settle time, and compares the captured truth table against EXPECTED.
module truth_table_checker #(
  parameter int                 N_IN     = 3,
  parameter int                 SETTLE   = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'hEE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch_cnt,
  output logic                 err_valid,
  output logic [N_IN-1:0]      first_err_idx
);

  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_IDX    = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e              state_q,     state_d;
  logic [N_IN-1:0]     idx_q,       idx_d;
  logic [7:0]          cnt_q,       cnt_d;
  logic [2**N_IN-1:0]  table_q,     table_d;
  logic [N_IN:0]       mism_q,      mism_d;
  logic                err_valid_q, err_valid_d;
  logic [N_IN-1:0]     first_err_q, first_err_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                pass_q,      pass_d;
  logic                miss;

  assign miss = (y_in != EXPECTED[idx_q]);

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    table_d     = table_q;
    mism_d      = mism_q;
    err_valid_d = err_valid_q;
    first_err_d = first_err_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          table_d     = '0;
          mism_d      = '0;
          err_valid_d = 1'b0;
          first_err_d = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          idx_d       = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
        else                      cnt_d   = cnt_q + 8'd1;
      end
      S_SAMPLE: begin
        table_d[idx_q] = y_in;
        if (miss) begin
          mism_d = mism_q + 1'b1;
          if (!err_valid_q) begin
            first_err_d = idx_q;
            err_valid_d = 1'b1;
          end
        end
        // pass must reflect the count including this final compare.
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (mism_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      table_q     <= '0;
      mism_q      <= '0;
      err_valid_q <= 1'b0;
      first_err_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop sees pre-edge values of the others.
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      table_q     <= table_d;
      mism_q      <= mism_d;
      err_valid_q <= err_valid_d;
      first_err_q <= first_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // The index and the driven vector advance together, so one register serves both.
  assign vec_out       = idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign table_out     = table_q;
  assign mismatch_cnt  = mism_q;
  assign err_valid     = err_valid_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: a default 3-input instance and a 2-input XOR instance,
// each driven by a lookup-table "DUT" whose function is chosen per sweep.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] vec_out;
  logic       y_in;
  logic       busy, done, pass, err_valid;
  logic [7:0] table_out;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_err_idx;
  logic [7:0] func_tbl = 8'hEE;

  logic       start2 = 1'b0;
  logic [1:0] vec2;
  logic       y2;
  logic       busy2, done2, pass2, ev2;
  logic [3:0] table2;
  logic [2:0] mism2;
  logic [1:0] fe2;
  logic [3:0] func2 = 4'h6;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign y_in = func_tbl[vec_out];
  assign y2   = func2[vec2];

  truth_table_checker dut (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .table_out(table_out),
    .mismatch_cnt(mismatch_cnt), .err_valid(err_valid), .first_err_idx(first_err_idx)
  );

  truth_table_checker #(.N_IN(2), .SETTLE(1), .EXPECTED(4'h6)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .vec_out(vec2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .table_out(table2),
    .mismatch_cnt(mism2), .err_valid(ev2), .first_err_idx(fe2)
  );

  // Reference: the captured table is the function itself; errors are the bits differing
  // from the expected table, first error is the lowest such bit.
  task automatic model(input int nv, input logic [7:0] f, input logic [7:0] exp_tbl,
                       output int mis, output int first);
    mis = 0;
    first = 0;
    for (int i = nv - 1; i >= 0; i--) begin
      if (f[i] != exp_tbl[i]) begin
        mis++;
        first = i;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if ({vec_out, busy, done, pass, table_out, mismatch_cnt, err_valid, first_err_idx} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got vec=%0h busy=%b done=%b pass=%b tbl=%0h mis=%0d ev=%b fe=%0d want all 0",
               vec_out, busy, done, pass, table_out, mismatch_cnt, err_valid, first_err_idx);
    end
    n_vec++;
    if ({vec2, busy2, done2, pass2, table2, mism2, ev2, fe2} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs2: got %0h want 0", {vec2, busy2, done2, pass2, table2, mism2, ev2, fe2});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one full sweep of the default instance with function f. With restarts set,
  // start is re-pulsed at cycles 5, 12 and one random cycle while busy.
  task automatic run_sweep(input logic [7:0] f, input bit restarts);
    int mis, first, rnd;
    model(8, f, 8'hEE, mis, first);
    rnd = int'($urandom_range(1, 22));
    func_tbl = f;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_vec++;
    if ({table_out, mismatch_cnt, err_valid, first_err_idx, done, pass} !== '0) begin
      n_err++;
      $display("FAIL start_clears: got tbl=%0h mis=%0d ev=%b fe=%0d done=%b pass=%b want all 0",
               table_out, mismatch_cnt, err_valid, first_err_idx, done, pass);
    end
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clk);
      n_vec++;
      if (vec_out !== 3'(k / 3) || busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL sweep_step k=%0d: got vec=%0d busy=%b done=%b want vec=%0d busy=1 done=0",
                 k, vec_out, busy, done, k / 3);
      end
      start = restarts && k <= 22 && (k == 5 || k == 12 || k == rnd);
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || vec_out !== 3'd7) begin
      n_err++;
      $display("FAIL done_latency: got done=%b busy=%b vec=%0d want done=1 busy=0 vec=7", done, busy, vec_out);
    end
    n_vec++;
    if (table_out !== f || mismatch_cnt !== 4'(mis) || pass !== (mis == 0)) begin
      n_err++;
      $display("FAIL results f=%0h: got tbl=%0h mis=%0d pass=%b want tbl=%0h mis=%0d pass=%b",
               f, table_out, mismatch_cnt, pass, f, mis, mis == 0);
    end
    n_vec++;
    if (err_valid !== (mis != 0) || first_err_idx !== 3'(first)) begin
      n_err++;
      $display("FAIL first_err f=%0h: got ev=%b fe=%0d want ev=%b fe=%0d",
               f, err_valid, first_err_idx, mis != 0, first);
    end
    func_tbl = ~f;
    repeat (3) @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || table_out !== f || mismatch_cnt !== 4'(mis)) begin
      n_err++;
      $display("FAIL done_hold f=%0h: got done=%b busy=%b tbl=%0h mis=%0d want done=1 busy=0 tbl=%0h mis=%0d",
               f, done, busy, table_out, mismatch_cnt, f, mis);
    end
  endtask

  task automatic test_async_reset();
    bit hit = 1'b0;
    func_tbl = 8'h00;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (vec_out == 3'd4) hit = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL reach_vec4: got vec=%0d want 4 within 40 cycles", vec_out);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({vec_out, busy, done, pass, table_out, mismatch_cnt, err_valid, first_err_idx} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got vec=%0h busy=%b done=%b tbl=%0h mis=%0d ev=%b fe=%0d want all 0",
               vec_out, busy, done, table_out, mismatch_cnt, err_valid, first_err_idx);
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 3'd0) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b done=%b vec=%0d want 0 0 0", busy, done, vec_out);
    end
    run_sweep(8'hEE, 1'b0);
  endtask

  task automatic run_sweep2(input logic [3:0] f);
    int mis, first;
    model(4, {4'h0, f}, 8'h06, mis, first);
    func2 = f;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      n_vec++;
      if (vec2 !== 2'(k / 2) || busy2 !== 1'b1 || done2 !== 1'b0) begin
        n_err++;
        $display("FAIL small_step k=%0d: got vec=%0d busy=%b done=%b want vec=%0d busy=1 done=0",
                 k, vec2, busy2, done2, k / 2);
      end
    end
    @(negedge clk);
    n_vec++;
    if (done2 !== 1'b1 || table2 !== f || mism2 !== 3'(mis) || pass2 !== (mis == 0) ||
        ev2 !== (mis != 0) || fe2 !== 2'(first)) begin
      n_err++;
      $display("FAIL small_results f=%0h: got done=%b tbl=%0h mis=%0d pass=%b ev=%b fe=%0d want 1 %0h %0d %b %b %0d",
               f, done2, table2, mism2, pass2, ev2, fe2, f, mis, mis == 0, mis != 0, first);
    end
  endtask

  initial begin
    test_reset();
    run_sweep(8'hEE, 1'b0);
    run_sweep(8'h00, 1'b0);
    run_sweep(8'hFF, 1'b0);
    run_sweep(8'hEE, 1'b1);
    run_sweep(8'hEE, 1'b0);
    for (int i = 0; i < 6; i++) run_sweep(8'($urandom), i[0]);
    test_async_reset();
    run_sweep2(4'h6);
    for (int i = 0; i < 3; i++) run_sweep2(4'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
